// File: rtl/edge_scan_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : edge_scan_pkg                                          |
// | Description : Shared types and constants for the edge-result scan    |
// |               controller (state enum, sizes, saturating adder).      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package edge_scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int NUM_WORDS_C  = 64;  // 4 banks x 16 words
  localparam int BANK_WORDS_C = 16;
  localparam int CNT_W_C      = 12;
  localparam int IDX_W_C      = 6;

  // Add a word popcount to the running edge count, clamping at all-ones.
  function automatic logic [CNT_W_C-1:0] sat_add(input logic [CNT_W_C-1:0] acc,
                                                 input logic [5:0]         inc);
    logic [CNT_W_C:0] sum;
    sum = {1'b0, acc} + (CNT_W_C+1)'(inc);
    return sum[CNT_W_C] ? {CNT_W_C{1'b1}} : sum[CNT_W_C-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/edge_scan_ctrl_popcnt.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : popcnt32                                               |
// | Description : Combinational population count of a 32-bit word.      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module popcnt32 (
  input  logic [31:0] data_i,
  output logic [5:0]  count_o
);

  // Sum the individual bits; synthesis folds this into an adder tree.
  always_comb begin
    count_o = 6'd0;
    for (int i = 0; i < 32; i++) begin
      count_o = count_o + 6'(data_i[i]);
    end
  end

endmodule
`default_nettype wire

// File: rtl/edge_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : edge_scan_ctrl                                         |
// | Description : Walks the 64-word edge-result readout mux, streams     |
// |               each word downstream with its index and accumulates    |
// |               the total number of set bits.                          |
// |               Optional build macro EDGE_SCAN_SKIP_ZERO_EN: zero words |
// |               are skipped; a one-word staging register lets out_last |
// |               land on the final non-zero word.                       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module edge_scan_ctrl
  import edge_scan_pkg::*;
#(
  parameter int NUM_WORDS = NUM_WORDS_C,
  parameter int WORD_W    = 32
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                start,
  input  logic                abort,
  output logic [1:0]          sel1,
  output logic [7:0]          sel2,
  input  logic [WORD_W-1:0]   rd_data,
  output logic [WORD_W-1:0]   out_data,
  output logic [IDX_W_C-1:0]  out_idx,
  output logic                out_valid,
  output logic                out_last,
  input  logic                out_ready,
  output logic                busy,
  output logic                done,
  output logic [CNT_W_C-1:0]  edge_cnt
);

  localparam int WSEL_W = $clog2(BANK_WORDS_C);

  state_e               state_q;
  logic [IDX_W_C-1:0]   addr_q;
  logic [WORD_W-1:0]    out_data_q;
  logic [IDX_W_C-1:0]   out_idx_q;
  logic                 out_valid_q;
  logic                 out_last_q;
  logic                 done_q;
  logic [CNT_W_C-1:0]   cnt_q;

`ifdef EDGE_SCAN_SKIP_ZERO_EN
  logic [WORD_W-1:0]    stg_data_q;
  logic [IDX_W_C-1:0]   stg_idx_q;
  logic                 stg_valid_q;
`endif

  logic [5:0]           pop_d;
  logic [CNT_W_C-1:0]   cnt_d;
  logic                 last_addr_d;
  logic                 can_load_d;
  logic [IDX_W_C-1:0]   addr_adv_d;
  state_e               state_adv_d;

  popcnt32 u_popcnt (
    .data_i  (rd_data),
    .count_o (pop_d)
  );

  // Readout address split into bank and word-in-bank; upper sel2 bits unused.
  assign sel1 = addr_q[IDX_W_C-1:WSEL_W];
  assign sel2 = 8'(addr_q[WSEL_W-1:0]);

  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign done      = done_q;
  assign edge_cnt  = cnt_q;
  assign busy      = (state_q != IDLE);

  assign cnt_d       = sat_add(cnt_q, pop_d);
  assign last_addr_d = (addr_q == IDX_W_C'(NUM_WORDS - 1));
  // Output register may take a new word when empty or being consumed now.
  assign can_load_d  = !out_valid_q || out_ready;

  // Address step: the final word moves to DRAIN and parks addr at 0.
  always_comb begin
    addr_adv_d  = last_addr_d ? '0 : addr_q + IDX_W_C'(1);
    state_adv_d = last_addr_d ? DRAIN : SCAN;
  end

  // Scan FSM with registered stream outputs, done pulse and edge count.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      cnt_q       <= '0;
`ifdef EDGE_SCAN_SKIP_ZERO_EN
      stg_data_q  <= '0;
      stg_idx_q   <= '0;
      stg_valid_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if ((state_q != IDLE) && abort) begin
        // Abort beats any capture; the partial edge count is kept.
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
        done_q      <= 1'b1;
        addr_q      <= '0;
        state_q     <= IDLE;
`ifdef EDGE_SCAN_SKIP_ZERO_EN
        stg_valid_q <= 1'b0;
`endif
      end else begin
        unique case (state_q)
          IDLE: begin
            if (start) begin
              addr_q  <= '0;
              cnt_q   <= '0;
              state_q <= SCAN;
            end
          end
          SCAN: begin
`ifdef EDGE_SCAN_SKIP_ZERO_EN
            if (out_valid_q && out_ready) begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
            end
            if (rd_data == '0) begin
              addr_q  <= addr_adv_d;
              state_q <= state_adv_d;
            end else if (!stg_valid_q) begin
              stg_data_q  <= rd_data;
              stg_idx_q   <= addr_q;
              stg_valid_q <= 1'b1;
              cnt_q       <= cnt_d;
              addr_q      <= addr_adv_d;
              state_q     <= state_adv_d;
            end else if (can_load_d) begin
              // A later non-zero word exists, so the staged one is not last.
              out_data_q  <= stg_data_q;
              out_idx_q   <= stg_idx_q;
              out_valid_q <= 1'b1;
              out_last_q  <= 1'b0;
              stg_data_q  <= rd_data;
              stg_idx_q   <= addr_q;
              cnt_q       <= cnt_d;
              addr_q      <= addr_adv_d;
              state_q     <= state_adv_d;
            end
`else
            if (can_load_d) begin
              out_data_q  <= rd_data;
              out_idx_q   <= addr_q;
              out_valid_q <= 1'b1;
              out_last_q  <= last_addr_d;
              cnt_q       <= cnt_d;
              addr_q      <= addr_adv_d;
              state_q     <= state_adv_d;
            end
`endif
          end
          DRAIN: begin
`ifdef EDGE_SCAN_SKIP_ZERO_EN
            if (stg_valid_q) begin
              if (can_load_d) begin
                out_data_q  <= stg_data_q;
                out_idx_q   <= stg_idx_q;
                out_valid_q <= 1'b1;
                out_last_q  <= 1'b1;
                stg_valid_q <= 1'b0;
              end
            end else if (can_load_d) begin
              // Covers the all-zero scan: done with no beat ever shown.
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              done_q      <= 1'b1;
              state_q     <= IDLE;
            end
`else
            if (out_valid_q && out_ready) begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              done_q      <= 1'b1;
              state_q     <= IDLE;
            end
`endif
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_edge_scan_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | Module      : tb_edge_scan_ctrl                                      |
// | Description : Self-checking bench for edge_scan_ctrl with a word     |
// |               memory model and a list-based expected stream.         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_edge_scan_ctrl;

  logic        CLK = 1'b0;
  logic        RST, start, abort, out_ready;
  logic [1:0]  sel1;
  logic [7:0]  sel2;
  logic [31:0] rd_data, out_data;
  logic [5:0]  out_idx;
  logic        out_valid, out_last, busy, done;
  logic [11:0] edge_cnt;

  logic [31:0] mem [64];

  int tests = 0;
  int fails = 0;

  // observations from the last scan
  int          obs_idx[$];
  logic [31:0] obs_data[$];
  bit          obs_last[$];
  int          obs_cyc[$];
  int          done_cyc, done_pulses, abort_cyc, stall_err, sel_err;
  logic [11:0] cnt_at_done;
  logic        valid_at_done, last_at_done;
  bit          timed_out;

  // reference stream
  int          exp_idx[$];
  logic [31:0] exp_data[$];
  int          exp_cnt;

  always #5 CLK = ~CLK;

  assign rd_data = mem[{sel1, sel2[3:0]}];

  edge_scan_ctrl dut (
    .CLK(CLK), .RST(RST), .start(start), .abort(abort),
    .sel1(sel1), .sel2(sel2), .rd_data(rd_data),
    .out_data(out_data), .out_idx(out_idx), .out_valid(out_valid),
    .out_last(out_last), .out_ready(out_ready),
    .busy(busy), .done(done), .edge_cnt(edge_cnt)
  );

  // Expected stream: every word in address order (non-zero only in skip builds).
  task automatic build_model();
    exp_idx.delete();
    exp_data.delete();
    exp_cnt = 0;
    for (int k = 0; k < 64; k++) begin
`ifdef EDGE_SCAN_SKIP_ZERO_EN
      if (mem[k] == 32'd0) continue;
`endif
      exp_idx.push_back(k);
      exp_data.push_back(mem[k]);
      exp_cnt += $countones(mem[k]);
    end
    if (exp_cnt > 4095) exp_cnt = 4095;
  endtask

  // rdy_mode: 0 = always ready, 1 = toggling, 2 = random.
  task automatic do_scan(input int rdy_mode, input int abort_idx, input int restart_cyc);
    int cyc;
    bit stalled;
    logic [31:0] pdata;
    logic [5:0]  pidx;
    obs_idx.delete(); obs_data.delete(); obs_last.delete(); obs_cyc.delete();
    done_cyc = -1; done_pulses = 0; abort_cyc = -1; stall_err = 0; sel_err = 0;
    timed_out = 0; stalled = 0; pdata = '0; pidx = '0;
    @(negedge CLK);
    start = 1'b1; abort = 1'b0; out_ready = 1'b1;
    cyc = 0;
    while (1) begin
      @(negedge CLK);
      cyc++;
      start = (cyc == restart_cyc);
      abort = 1'b0;
      if (stalled && !(out_valid && out_data == pdata && out_idx == pidx)) stall_err++;
      if (sel2[7:4] != 4'd0) sel_err++;
      if (done) begin
        done_pulses++;
        if (done_cyc < 0) begin
          done_cyc = cyc; cnt_at_done = edge_cnt;
          valid_at_done = out_valid; last_at_done = out_last;
        end
      end
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = cyc[0];
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (abort_idx >= 0 && abort_cyc < 0 && out_valid && out_idx == 6'(abort_idx)) begin
        abort = 1'b1;
        abort_cyc = cyc;
      end
      if (out_valid && out_ready) begin
        obs_idx.push_back(int'(out_idx));
        obs_data.push_back(out_data);
        obs_last.push_back(out_last);
        obs_cyc.push_back(cyc);
      end
      stalled = out_valid && !out_ready && !abort;
      pdata = out_data;
      pidx  = out_idx;
      if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
      if (cyc > 1500) begin timed_out = 1; break; end
    end
    start = 1'b0; abort = 1'b0; out_ready = 1'b1;
  endtask

  task automatic test_reset();
    RST = 1'b1; start = 1'b1; abort = 1'b1; out_ready = 1'b0;
    repeat (3) @(negedge CLK);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
    tests++; if (out_last !== 1'b0) begin fails++; $display("FAIL reset_last: got %0b want 0", out_last); end
    tests++; if (out_data !== 32'd0) begin fails++; $display("FAIL reset_data: got %h want 0", out_data); end
    tests++; if (out_idx !== 6'd0) begin fails++; $display("FAIL reset_idx: got %0d want 0", out_idx); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %0b want 0", done); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0b want 0", busy); end
    tests++; if (edge_cnt !== 12'd0) begin fails++; $display("FAIL reset_cnt: got %0d want 0", edge_cnt); end
    tests++; if ({sel1, sel2} !== 10'd0) begin fails++; $display("FAIL reset_sel: got %h want 0", {sel1, sel2}); end
    RST = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_random();
    for (int it = 0; it < 3; it++) begin
      for (int k = 0; k < 64; k++) mem[k] = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      build_model();
      do_scan(2, -1, -1);
      tests++; if (timed_out) begin fails++; $display("FAIL rand_timeout: got timeout want done"); end
      tests++; if (obs_idx.size() != exp_idx.size()) begin fails++; $display("FAIL rand_beats: got %0d want %0d", obs_idx.size(), exp_idx.size()); end
      for (int i = 0; i < obs_idx.size() && i < exp_idx.size(); i++) begin
        tests++;
        if (obs_idx[i] != exp_idx[i] || obs_data[i] !== exp_data[i] || obs_last[i] != (i == exp_idx.size() - 1)) begin
          fails++;
          $display("FAIL rand_beat%0d: got idx %0d data %h last %0b want idx %0d data %h last %0b",
                   i, obs_idx[i], obs_data[i], obs_last[i], exp_idx[i], exp_data[i], (i == exp_idx.size() - 1));
        end
      end
      tests++; if (cnt_at_done !== 12'(exp_cnt)) begin fails++; $display("FAIL rand_cnt: got %0d want %0d", cnt_at_done, exp_cnt); end
      tests++; if (done_pulses != 1) begin fails++; $display("FAIL rand_done_pulses: got %0d want 1", done_pulses); end
      tests++; if (stall_err != 0) begin fails++; $display("FAIL rand_stall_hold: got %0d changes want 0", stall_err); end
      tests++; if (sel_err != 0) begin fails++; $display("FAIL rand_sel2_hi: got %0d nonzero want 0", sel_err); end
      tests++; if (valid_at_done !== 1'b0) begin fails++; $display("FAIL rand_valid_at_done: got %0b want 0", valid_at_done); end
    end
  endtask

`ifndef EDGE_SCAN_SKIP_ZERO_EN
  task automatic test_all_ones();
    int nlast;
    for (int k = 0; k < 64; k++) mem[k] = 32'hFFFF_FFFF;
    do_scan(0, -1, -1);
    nlast = 0;
    foreach (obs_last[i]) if (obs_last[i]) nlast++;
    tests++; if (obs_idx.size() != 64) begin fails++; $display("FAIL ones_beats: got %0d want 64", obs_idx.size()); end
    for (int i = 0; i < obs_idx.size() && i < 64; i++) begin
      tests++;
      if (obs_idx[i] != i || obs_cyc[i] != i + 2) begin
        fails++; $display("FAIL ones_beat%0d: got idx %0d cycle %0d want idx %0d cycle %0d", i, obs_idx[i], obs_cyc[i], i, i + 2);
      end
    end
    tests++; if (nlast != 1 || obs_last.size() != 64 || !obs_last[63]) begin fails++; $display("FAIL ones_last: got %0d lasts want 1 on idx 63", nlast); end
    tests++; if (done_cyc != 66) begin fails++; $display("FAIL ones_done_cycle: got %0d want 66", done_cyc); end
    tests++; if (cnt_at_done !== 12'd2048) begin fails++; $display("FAIL ones_cnt: got %0d want 2048", cnt_at_done); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL ones_busy_after: got %0b want 0", busy); end
  endtask

  task automatic test_count_stall();
    for (int k = 0; k < 64; k++) mem[k] = 32'(k);
    build_model();
    do_scan(1, -1, 30);  // also a start pulse mid-scan, which must be ignored
    tests++; if (obs_idx.size() != 64) begin fails++; $display("FAIL stall_beats: got %0d want 64", obs_idx.size()); end
    for (int i = 0; i < obs_idx.size() && i < 64; i++) begin
      tests++;
      if (obs_idx[i] != i || obs_data[i] !== 32'(i)) begin
        fails++; $display("FAIL stall_beat%0d: got idx %0d data %h want idx %0d", i, obs_idx[i], obs_data[i], i);
      end
    end
    tests++; if (stall_err != 0) begin fails++; $display("FAIL stall_hold: got %0d changes want 0", stall_err); end
    tests++; if (cnt_at_done !== 12'(exp_cnt)) begin fails++; $display("FAIL stall_cnt: got %0d want %0d", cnt_at_done, exp_cnt); end
    tests++; if (done_pulses != 1) begin fails++; $display("FAIL stall_done_pulses: got %0d want 1", done_pulses); end
  endtask

  task automatic test_abort();
    for (int k = 0; k < 64; k++) mem[k] = 32'(k);
    do_scan(0, 20, -1);
    tests++; if (abort_cyc < 0 || done_cyc != abort_cyc + 1) begin fails++; $display("FAIL abort_done_cycle: got %0d want %0d", done_cyc, abort_cyc + 1); end
    tests++; if (valid_at_done !== 1'b0 || last_at_done !== 1'b0) begin fails++; $display("FAIL abort_valid: got valid %0b last %0b want 0 0", valid_at_done, last_at_done); end
    tests++; if (cnt_at_done !== 12'd42) begin fails++; $display("FAIL abort_cnt: got %0d want 42", cnt_at_done); end
    tests++; if (done_pulses != 1) begin fails++; $display("FAIL abort_done_pulses: got %0d want 1", done_pulses); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy: got %0b want 0", busy); end
  endtask

  task automatic test_start_rst();
    int cyc, dp;
    int seen[$];
    bit hit;
    for (int k = 0; k < 64; k++) mem[k] = 32'(k);
    @(negedge CLK);
    start = 1'b1; out_ready = 1'b1; cyc = 0; hit = 0;
    while (cyc < 100) begin
      @(negedge CLK);
      cyc++;
      start = (cyc == 5);
      if (out_valid) seen.push_back(int'(out_idx));
      if (out_valid && out_idx == 6'd10) begin RST = 1'b1; hit = 1; break; end
    end
    start = 1'b0;
    tests++; if (!hit) begin fails++; $display("FAIL rst_reach_idx10: got no idx 10 want idx 10"); end
    tests++; if (seen.size() != 11) begin fails++; $display("FAIL rst_prior_beats: got %0d want 11", seen.size()); end
    for (int i = 0; i < seen.size() && i < 11; i++) begin
      tests++; if (seen[i] != i) begin fails++; $display("FAIL rst_prior_idx%0d: got %0d want %0d", i, seen[i], i); end
    end
    @(negedge CLK);
    RST = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== 32'd0 || out_idx !== 6'd0 ||
        edge_cnt !== 12'd0 || done !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL rst_outputs: got v%0b l%0b d%h i%0d c%0d done%0b busy%0b want all 0",
               out_valid, out_last, out_data, out_idx, edge_cnt, done, busy);
    end
    dp = 0;
    repeat (6) begin @(negedge CLK); if (done) dp++; end
    tests++; if (dp != 0) begin fails++; $display("FAIL rst_no_done: got %0d pulses want 0", dp); end
  endtask
`else
  task automatic test_skip_zero();
    for (int k = 0; k < 64; k++) mem[k] = 32'd0;
    mem[5]  = 32'h0000_0F01;
    mem[63] = 32'h8000_0003;
    do_scan(0, -1, -1);
    tests++; if (obs_idx.size() != 2) begin fails++; $display("FAIL skip_beats: got %0d want 2", obs_idx.size()); end
    if (obs_idx.size() == 2) begin
      tests++; if (obs_idx[0] != 5 || obs_last[0] || obs_data[0] !== 32'h0000_0F01) begin fails++; $display("FAIL skip_first: got idx %0d last %0b data %h want 5 0 00000f01", obs_idx[0], obs_last[0], obs_data[0]); end
      tests++; if (obs_idx[1] != 63 || !obs_last[1] || obs_data[1] !== 32'h8000_0003) begin fails++; $display("FAIL skip_second: got idx %0d last %0b data %h want 63 1 80000003", obs_idx[1], obs_last[1], obs_data[1]); end
    end
    tests++; if (cnt_at_done !== 12'd8) begin fails++; $display("FAIL skip_cnt: got %0d want 8", cnt_at_done); end
    for (int k = 0; k < 64; k++) mem[k] = 32'd0;
    do_scan(0, -1, -1);
    tests++; if (obs_idx.size() != 0) begin fails++; $display("FAIL skip_zero_beats: got %0d want 0", obs_idx.size()); end
    tests++; if (done_pulses != 1) begin fails++; $display("FAIL skip_zero_done: got %0d pulses want 1", done_pulses); end
    tests++; if (cnt_at_done !== 12'd0) begin fails++; $display("FAIL skip_zero_cnt: got %0d want 0", cnt_at_done); end
  endtask
`endif

  initial begin
    RST = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    for (int k = 0; k < 64; k++) mem[k] = 32'd0;
    test_reset();
`ifndef EDGE_SCAN_SKIP_ZERO_EN
    test_all_ones();
    test_count_stall();
    test_abort();
    test_start_rst();
`else
    test_skip_zero();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/edge_scan_ctrl.md
EDGE_SCAN_CTRL -- requirements
Module: edge_scan_ctrl

Interface
REQ-001 SHALL have parameter NUM_WORDS, default 64, number of 32-bit words in the edge result (4 banks x 16 words).
REQ-002 SHALL have parameter WORD_W, default 32, read data width; only 32 is supported.
REQ-003 SHALL have port CLK, input, 1, the single clock; all logic is on the rising edge.
REQ-004 SHALL have port RST, input, 1, synchronous reset, active-high.
REQ-005 SHALL have port start, input, 1, one-cycle request to begin a scan; honoured only in IDLE.
REQ-006 SHALL have port abort, input, 1, terminates an active scan.
REQ-007 SHALL have port sel1, output, 2, bank select to the edge-result readout mux.
REQ-008 SHALL have port sel2, output, 8, word select within the bank; bits [7:4] are always 0.
REQ-009 SHALL have port rd_data, input, 32, combinational readout for the current {sel1,sel2}.
REQ-010 SHALL have ports out_data (output, 32), out_idx (output, 6), out_valid (output, 1), out_last (output, 1) and out_ready (input, 1), forming the downstream word stream.
REQ-011 SHALL have ports busy (output, 1), done (output, 1, one-cycle pulse) and edge_cnt (output, 12, total set bits emitted in the last scan).

Function
REQ-012 SHALL implement FSM IDLE -> SCAN -> DRAIN -> IDLE; busy = (state != IDLE).
REQ-013 In IDLE, start=1 SHALL clear addr and edge_cnt and enter SCAN on the next cycle.
REQ-014 SHALL drive {sel1,sel2[3:0]} = addr[5:0] combinationally from the registered addr; addr = 0 outside SCAN.
REQ-015 In SCAN, when the output register is empty or (out_valid & out_ready), SHALL capture rd_data, addr into out_data, out_idx, set out_valid, add popcount(rd_data) to edge_cnt, and increment addr.
REQ-016 When the output register is full and out_ready=0, SHALL hold addr, out_data, out_idx and out_valid unchanged.
REQ-017 SHALL assert out_last together with out_valid for the word with idx NUM_WORDS-1.
REQ-018 After capturing addr NUM_WORDS-1, SHALL enter DRAIN; addr SHALL NOT wrap.
REQ-019 In DRAIN, on out_valid & out_ready, SHALL clear out_valid, pulse done for one cycle and return to IDLE.
REQ-020 Latency: with out_ready held at 1, start in cycle 0 SHALL give the first out_valid in cycle 2, one word per cycle, the last word in cycle 65 and done in cycle 66.
REQ-021 start while busy SHALL be ignored.
REQ-022 abort in SCAN or DRAIN SHALL clear out_valid and out_last, pulse done, leave edge_cnt at the partial sum and return to IDLE next cycle; abort has priority over capture.
REQ-023 edge_cnt SHALL be 12 bits (maximum 2048) and SHALL saturate at 4095, which cannot be reached at the default parameters.

Reset
REQ-024 RST=1 SHALL force IDLE with addr=0, out_data=0, out_idx=0, out_valid=0, out_last=0, done=0 and edge_cnt=0, overriding start and abort.
REQ-025 RST asserted mid-scan SHALL discard the in-flight word with no done pulse.

Configuration
REQ-026 With EDGE_SCAN_SKIP_ZERO_EN defined, SCAN SHALL advance addr past words where rd_data==0 without loading the output register.
REQ-027 In that mode, out_last SHALL be on the last non-zero word; if no word is non-zero, done SHALL pulse with no out_valid.
REQ-028 With EDGE_SCAN_SKIP_ZERO_EN undefined, SHALL emit all NUM_WORDS words.

Structure
REQ-029 A shared package edge_scan_pkg SHALL hold the state enum (IDLE, SCAN, DRAIN), NUM_WORDS_C=64, BANK_WORDS_C=16 and CNT_W_C=12.
REQ-030 SHALL instantiate one sub-module popcnt32 (32-bit combinational population count, 6-bit result).

Verification
REQ-031 Scenario: all words = 0xFFFFFFFF, out_ready=1, start in cycle 0 -> 64 beats in cycles 2..65, out_last on idx 63, done in cycle 66, edge_cnt=2048.
REQ-032 Scenario: word k = k, out_ready toggling 1/0 -> out_idx sequence 0..63 with no gaps or duplicates, and out_data stable while stalled.
REQ-033 Scenario: abort while out_idx=20 -> done next cycle, out_valid=0, edge_cnt = sum of popcount(0..20) = 42.
REQ-034 Scenario: start during SCAN, and RST at idx 10 -> the start is ignored; after RST all outputs are 0 and there is no done pulse.
REQ-035 Scenario: EDGE_SCAN_SKIP_ZERO_EN defined with only words 5 and 63 non-zero -> exactly 2 beats (idx 5, then idx 63 with out_last); all-zero memory -> done with 0 beats.
